// File: rtl/stack_id_collector.sv
// Base-die receiver for the stack self-test handshake: decodes layer frames into a chip ID/power table.
// Optional macro STACK_PWR_CHECK_EN enables the sticky max-drive power flag (err_power).
module stack_id_collector #(
  parameter int unsigned MAX_CHIPS = 8,
  parameter int unsigned TIMEOUT   = 63,
  localparam int unsigned AW = (MAX_CHIPS > 1) ? $clog2(MAX_CHIPS) : 1
) (
  input  logic          div_8_clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [31:0]   data_in,
  input  logic [AW-1:0] rd_addr,
  output logic [8:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic [3:0]    chip_count,
  output logic [3:0]    bad_frames,
  output logic          err_order,
  output logic          err_power
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LISTEN = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  marker;
    logic [3:0]  power;
    logic [3:0]  next_id;
    logic [3:0]  chip_id;
    logic [15:0] sync;
  } frame_t;

  state_t          state;
  logic [4:0]      exp_id;
  logic [7:0]      idle_timer;
  logic [DEPTH-1:0] ent_valid;
  logic [3:0]      ent_power [DEPTH];

  frame_t          frame_c;
  logic            frame_ok_c;
  logic            is_new_c;
  logic            is_retry_c;
  logic            hit_c;
  logic            accept_c;
  logic [AW-1:0]   wr_idx_c;
  logic [7:0]      timer_inc_c;

  // Frame decode and acceptance classification
  always_comb begin
    frame_c     = frame_t'(data_in);
    frame_ok_c  = (frame_c.marker == 4'hA) && (frame_c.sync == 16'hBEEF) &&
                  (frame_c.next_id == 4'(frame_c.chip_id + 4'd1));
    is_new_c    = (5'(frame_c.chip_id) == exp_id);
    is_retry_c  = (frame_c.chip_id != 4'd0) && (5'(frame_c.chip_id) < exp_id);
    hit_c       = (state == S_LISTEN) && rx_valid && !start;
    accept_c    = hit_c && frame_ok_c && (is_new_c || is_retry_c);
    wr_idx_c    = AW'(frame_c.chip_id - 4'd1);
    timer_inc_c = idle_timer + 8'd1;
  end

  // Collection FSM, counters, flags and table writes
  always_ff @(posedge div_8_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      exp_id     <= 5'd1;
      idle_timer <= 8'd0;
      chip_count <= 4'd0;
      bad_frames <= 4'd0;
      err_order  <= 1'b0;
      ent_valid  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) ent_power[i] <= 4'd0;
    end else if (start) begin
      state      <= S_LISTEN;
      busy       <= 1'b1;
      done       <= 1'b0;
      exp_id     <= 5'd1;
      idle_timer <= 8'd0;
      chip_count <= 4'd0;
      bad_frames <= 4'd0;
      err_order  <= 1'b0;
      ent_valid  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) ent_power[i] <= 4'd0;
    end else if (state == S_LISTEN) begin
      if (hit_c && !frame_ok_c && (bad_frames != 4'hF))
        bad_frames <= bad_frames + 4'd1;
      if (hit_c && frame_ok_c && !is_new_c && !is_retry_c)
        err_order <= 1'b1;
      if (accept_c) begin
        idle_timer          <= 8'd0;
        ent_power[wr_idx_c] <= frame_c.power;
        if (is_new_c) begin
          ent_valid[wr_idx_c] <= 1'b1;
          chip_count          <= chip_count + 4'd1;
          exp_id              <= exp_id + 5'd1;
          if (chip_count + 4'd1 == 4'(MAX_CHIPS)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      end else begin
        idle_timer <= timer_inc_c;
        if (timer_inc_c == 8'(TIMEOUT)) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  // Registered table read; unwritten entries read as zero
  always_ff @(posedge div_8_clk or negedge rst_n) begin
    if (!rst_n)
      rd_data <= 9'h000;
    else if (ent_valid[rd_addr])
      rd_data <= {1'b1, ent_power[rd_addr], 4'(rd_addr) + 4'd1};
    else
      rd_data <= 9'h000;
  end

`ifdef STACK_PWR_CHECK_EN
  // Sticky flag: an accepted layer reported maximum drive
  always_ff @(posedge div_8_clk or negedge rst_n) begin
    if (!rst_n)
      err_power <= 1'b0;
    else if (start)
      err_power <= 1'b0;
    else if (accept_c && (frame_c.power == 4'hF))
      err_power <= 1'b1;
  end
`else
  assign err_power = 1'b0;
`endif

endmodule

// File: tb/tb_stack_id_collector.sv
// Directed self-checking bench for stack_id_collector (default parameters).
module tb_stack_id_collector;

  logic        div_8_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        start     = 1'b0;
  logic        rx_valid  = 1'b0;
  logic [31:0] data_in   = 32'h0;
  logic [2:0]  rd_addr   = 3'd0;
  logic [8:0]  rd_data;
  logic        busy, done, err_order, err_power;
  logic [3:0]  chip_count, bad_frames;

  int vectors     = 0;
  int miscompares = 0;

`ifdef STACK_PWR_CHECK_EN
  localparam logic PWR_EXP = 1'b1;
`else
  localparam logic PWR_EXP = 1'b0;
`endif

  stack_id_collector #(.MAX_CHIPS(8), .TIMEOUT(63)) dut (
    .div_8_clk (div_8_clk),
    .rst_n     (rst_n),
    .start     (start),
    .rx_valid  (rx_valid),
    .data_in   (data_in),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .chip_count(chip_count),
    .bad_frames(bad_frames),
    .err_order (err_order),
    .err_power (err_power)
  );

  always #5 div_8_clk = ~div_8_clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge div_8_clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d);
    rx_valid = 1'b1;
    data_in  = d;
    step(1);
    rx_valid = 1'b0;
    data_in  = 32'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic read_entry(input logic [2:0] a, output logic [8:0] d);
    rd_addr = a;
    step(1);
    d = rd_data;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] id, input logic [3:0] pwr);
    return {4'hA, pwr, 4'(id + 4'd1), id, 16'hBEEF};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    vectors++;
    if ({busy, done, chip_count, bad_frames, err_order, err_power} !== 12'h0) begin
      $display("FAIL reset_outputs: got busy=%b done=%b cnt=%0d bad=%0d eo=%b ep=%b want all 0",
               busy, done, chip_count, bad_frames, err_order, err_power);
      miscompares++;
    end
    vectors++;
    if (rd_data !== 9'h0) begin
      $display("FAIL reset_rd_data: got %h want 000", rd_data);
      miscompares++;
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_nominal();
    logic [8:0] d;
    pulse_start();
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL nominal_listen: got busy=%b done=%b want 1 0", busy, done);
      miscompares++;
    end
    send(32'hA121BEEF);
    send(32'hA132BEEF);
    send(32'hA143BEEF);
    step(62);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL nominal_pre_timeout: got busy=%b done=%b want 1 0", busy, done);
      miscompares++;
    end
    rd_addr = 3'd1;
    step(1);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL nominal_done: got busy=%b done=%b want 0 1", busy, done);
      miscompares++;
    end
    vectors++;
    if (chip_count !== 4'd3 || err_order !== 1'b0 || bad_frames !== 4'd0 || err_power !== 1'b0) begin
      $display("FAIL nominal_counts: got cnt=%0d eo=%b bad=%0d ep=%b want 3 0 0 0",
               chip_count, err_order, bad_frames, err_power);
      miscompares++;
    end
    vectors++;
    if (rd_data !== 9'h112) begin
      $display("FAIL nominal_rd1: got %h want 112", rd_data);
      miscompares++;
    end
    read_entry(3'd3, d);
    vectors++;
    if (d !== 9'h000) begin
      $display("FAIL nominal_rd3_invalid: got %h want 000", d);
      miscompares++;
    end
  endtask

  task automatic test_retry();
    logic [8:0] d;
    pulse_start();
    send(32'hA121BEEF);
    step(5);
    send(32'hA221BEEF);
    vectors++;
    if (chip_count !== 4'd1) begin
      $display("FAIL retry_count: got %0d want 1", chip_count);
      miscompares++;
    end
    step(62);
    vectors++;
    if (busy !== 1'b1) begin
      $display("FAIL retry_timer_restart: got busy=%b want 1", busy);
      miscompares++;
    end
    read_entry(3'd0, d);
    vectors++;
    if (d !== 9'h121) begin
      $display("FAIL retry_power: got %h want 121", d);
      miscompares++;
    end
    vectors++;
    if (done !== 1'b1) begin
      $display("FAIL retry_done: got %b want 1", done);
      miscompares++;
    end
  endtask

  task automatic test_malformed();
    pulse_start();
    send(32'hB121BEEF);
    send(32'hA121BEEE);
    send(32'hA131BEEF);
    send(32'hA143BEEF);
    vectors++;
    if (bad_frames !== 4'd3 || err_order !== 1'b1 || chip_count !== 4'd0) begin
      $display("FAIL malformed: got bad=%0d eo=%b cnt=%0d want 3 1 0", bad_frames, err_order, chip_count);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back_full();
    logic [8:0] d;
    pulse_start();
    for (int i = 1; i <= 7; i++) send(mk(4'(i), 4'(i - 1)));
    vectors++;
    if (done !== 1'b0 || chip_count !== 4'd7) begin
      $display("FAIL full_before8: got done=%b cnt=%0d want 0 7", done, chip_count);
      miscompares++;
    end
    send(mk(4'd8, 4'd7));
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || chip_count !== 4'd8) begin
      $display("FAIL full_done: got done=%b busy=%b cnt=%0d want 1 0 8", done, busy, chip_count);
      miscompares++;
    end
    send(32'hA1A9BEEF);
    read_entry(3'd7, d);
    vectors++;
    if (d !== 9'h178 || chip_count !== 4'd8) begin
      $display("FAIL full_hold: got rd=%h cnt=%0d want 178 8", d, chip_count);
      miscompares++;
    end
  endtask

  task automatic test_empty_timeout();
    int n;
    pulse_start();
    n = 0;
    while (!done && n < 200) begin
      step(1);
      n++;
    end
    vectors++;
    if (n !== 63 || chip_count !== 4'd0) begin
      $display("FAIL empty_timeout: got cycles=%0d cnt=%0d want 63 0", n, chip_count);
      miscompares++;
    end
  endtask

  task automatic test_power();
    pulse_start();
    send(32'hAF21BEEF);
    vectors++;
    if (err_power !== PWR_EXP || chip_count !== 4'd1) begin
      $display("FAIL power_flag: got ep=%b cnt=%0d want %b 1", err_power, chip_count, PWR_EXP);
      miscompares++;
    end
  endtask

  task automatic test_reset_restart();
    logic [8:0] d;
    pulse_start();
    send(32'hA121BEEF);
    send(32'hA132BEEF);
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({busy, done, chip_count, bad_frames, err_order, err_power} !== 12'h0 || rd_data !== 9'h0) begin
      $display("FAIL midreset_clear: got busy=%b done=%b cnt=%0d rd=%h want all 0",
               busy, done, chip_count, rd_data);
      miscompares++;
    end
    step(1);
    rst_n = 1'b1;
    read_entry(3'd0, d);
    vectors++;
    if (d !== 9'h000) begin
      $display("FAIL midreset_table: got %h want 000", d);
      miscompares++;
    end
    start    = 1'b1;
    rx_valid = 1'b1;
    data_in  = 32'hA121BEEF;
    step(1);
    start    = 1'b0;
    rx_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || chip_count !== 4'd0) begin
      $display("FAIL start_wins: got busy=%b cnt=%0d want 1 0", busy, chip_count);
      miscompares++;
    end
    send(32'hA121BEEF);
    vectors++;
    if (chip_count !== 4'd1 || err_order !== 1'b0) begin
      $display("FAIL restart_exp_id: got cnt=%0d eo=%b want 1 0", chip_count, err_order);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_retry();
    test_malformed();
    test_back_to_back_full();
    test_empty_timeout();
    test_power();
    test_reset_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
